// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving a one-bit ALU slice LSB first, with start/done handshake.
// Optional feature: define ALU_SERIAL_SLT_EN to support opcode 0111 (set-less-than).
module alu_serial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             err,
    output logic             slice_src1,
    output logic             slice_src2,
    output logic             slice_cin,
    output logic [3:0]       slice_ctrl,
    input  logic             slice_result,
    input  logic             slice_cout
);

    localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-2:0] res_q;
    logic [3:0]       op_q;
    logic             op_ok;
    logic             arith_q;
    logic             carry_q;
    logic [KW-1:0]    k;

    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] final_res;
    logic             co_w;
    logic             ov_w;
    logic             running;

    function automatic logic op_supported(input logic [3:0] o);
        case (o)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1101: op_supported = 1'b1;
`ifdef ALU_SERIAL_SLT_EN
            4'b0111: op_supported = 1'b1;
`endif
            default: op_supported = 1'b0;
        endcase
    endfunction

    function automatic logic op_arith(input logic [3:0] o);
        case (o)
            4'b0010, 4'b0110: op_arith = 1'b1;
`ifdef ALU_SERIAL_SLT_EN
            4'b0111: op_arith = 1'b1;
`endif
            default: op_arith = 1'b0;
        endcase
    endfunction

    // Operands shift right each RUN cycle, so bit 0 is always the current bit.
    assign running    = (state == RUN);
    assign slice_src1 = running & a_q[0];
    assign slice_src2 = running & b_q[0];
    assign slice_cin  = running & arith_q & carry_q;
    assign slice_ctrl = (running && op_ok) ? op_q : 4'b0000;

    always_comb begin
        word      = {slice_result, res_q};
        co_w      = arith_q & slice_cout;
        ov_w      = arith_q & (carry_q ^ slice_cout);
        final_res = op_ok ? word : '0;
`ifdef ALU_SERIAL_SLT_EN
        // SLT: sign of the difference corrected by overflow gives the signed compare.
        if (op_q == 4'b0111) begin
            final_res = {{(WIDTH-1){1'b0}}, slice_result ^ ov_w};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            err      <= 1'b0;
            op_q     <= 4'b0000;
            op_ok    <= 1'b0;
            arith_q  <= 1'b0;
            carry_q  <= 1'b0;
            k        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= op;
                        op_ok    <= op_supported(op);
                        arith_q  <= op_arith(op);
                        // SUB and SLT (op[2] set) start with carry-in 1 for two's complement.
                        carry_q  <= op_arith(op) & op[2];
                        k        <= '0;
                        result   <= '0;
                        zero     <= 1'b0;
                        cout     <= 1'b0;
                        overflow <= 1'b0;
                        err      <= 1'b0;
                        ready    <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= word[WIDTH-1:1];
                    carry_q <= slice_cout;
                    k       <= k + 1'b1;
                    if (k == K_LAST) begin
                        result   <= final_res;
                        zero     <= (final_res == '0);
                        cout     <= co_w;
                        overflow <= ov_w;
                        err      <= ~op_ok;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_serial_seq.md
# alu_serial_seq

Bit-serial sequencer that sits directly upstream of the one-bit ALU slice. It latches two WIDTH-bit operands and an ALU opcode, then drives the slice one bit per cycle, LSB first, threading the carry through a register. It collects the slice result bits into a WIDTH-bit word and produces the final result, zero, carry-out and overflow flags with a start/done handshake.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  request; accepted only when ready=1
- op  in  4  opcode: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 NAND
- a  in  WIDTH  operand 1, latched on accept
- b  in  WIDTH  operand 2, latched on accept
- ready  out  1  high in IDLE only
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  registered result, held until next accept
- zero  out  1  result == 0
- cout  out  1  carry out of MSB (arith ops), else 0
- overflow  out  1  signed overflow (ADD/SUB/SLT), else 0
- err  out  1  unsupported opcode, valid with done
- slice_src1, slice_src2, slice_cin  out  1 each  bit operands and carry to slice
- slice_ctrl  out  4  opcode to slice, equals latched op during RUN, 0000 otherwise
- slice_result, slice_cout  in  1 each  slice outputs, combinational from slice inputs

## Operation
- Slice contract: for 0110/0111, result = a^~b^cin, cout = maj(a,~b,cin); for 0010, the non-inverted form; for logic ops, bitwise on src1/src2 with cout ignored.
- FSM: IDLE -> RUN on start&ready; RUN -> DONE after bit WIDTH-1; DONE -> IDLE unconditionally.
- On accept: latch a, b, op; bit index k=0; carry_q = 1 for SUB/SLT, else 0.
- RUN cycle k: slice_src1=a_q[k], slice_src2=b_q[k], slice_cin=carry_q; at edge res[k]<=slice_result, carry_q<=slice_cout, k<=k+1.
- At k=WIDTH-1 (arith ops): overflow<=carry_q^slice_cout, cout<=slice_cout.
- SLT fix-up on entering DONE: result = {WIDTH-1 zeros, res[WIDTH-1]^overflow}; overflow and cout outputs are reported as computed by the subtraction.
- Logic ops: cout=0, overflow=0, slice_cin=0.
- zero computed on the final result, after the SLT fix-up.
- Unsupported opcode: full WIDTH-cycle run still occurs, slice_ctrl=0000; completes with result=0, zero=1, cout=0, overflow=0, err=1.
- start while ready=0 is ignored with no side effects; a, b, and op are don't-care outside accept.

## Timing
- Reset: state IDLE; result=0, zero=0, cout=0, overflow=0, err=0, done=0, ready=1, slice outputs 0.
- start accepted at edge T -> RUN during T+1..T+WIDTH -> done=1 in cycle T+WIDTH+1 -> ready=1 in cycle T+WIDTH+2. Latency WIDTH+1; throughput one op per WIDTH+2 cycles.
- result, zero, cout, overflow, and err update with the done edge and hold until the next accept. They are cleared at accept.
- rst mid-RUN or mid-DONE: abort, no done pulse, reset values the next cycle.
- Simultaneous rst and start: rst wins.

## Configuration
- ALU_SERIAL_SLT_EN defined: opcode 0111 is supported as above.
- ALU_SERIAL_SLT_EN undefined: 0111 is an unsupported opcode (err=1, result=0). No fix-up logic is compiled.

## Test plan
- ADD a=0x7FFFFFFF, b=0x00000001 -> result 0x80000000, overflow 1, cout 0, zero 0, done exactly 33 cycles after accept.
- SUB a=5, b=5 -> result 0, zero 1, cout 1, overflow 0; SUB a=0, b=1 -> 0xFFFFFFFF, cout 0.
- SLT a=0xFFFFFFFD, b=2 -> result 1; SLT a=0x7FFFFFFF, b=0x80000000 -> result 0, overflow 1. With the macro off, 0111 -> err 1, result 0, zero 1.
- NOR a=0, b=0 -> 0xFFFFFFFF; NAND a=0xFFFFFFFF, b=0xFFFFFFFF -> 0, zero 1; AND/OR of 0xF0F0F0F0 and 0x0FF00FF0 -> 0x00F000F0 / 0xFFF0FFF0.
- start pulsed in RUN cycle 5 with different operands -> ignored, original result returned; opcode 1111 -> err 1.
- rst asserted in RUN cycle 10 -> no done pulse, ready=1 and outputs 0 the next cycle; a new ADD 2+3 then yields 5.
